mem_bus_arbiter: RTL and testbench

- Shares one downstream memory_bus port (data RAM / MMIO) between two requesters: req0 = CPU data port, req1 = secondary master (DMA / sprite loader).
- Each requester sees the existing single-cycle dispatch_read/dispatch_write pulse + busy protocol unchanged.
- Arbiter captures pulses, selects one transaction, replays it downstream, and returns read data and busy per requester.
- Sits between the processor core / DMA and the memory-mapped bus decoder.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_slot.sv | 63 ++++++
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory bus arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_MW_W = 2;
    typedef struct packed {
        logic                  op_write;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_MW_W-1:0]   width;
        logic [ARB_DATA_W-1:0] wdata;
        logic                  pending;
    } arb_req_t;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;
endpackage

// File: rtl/mem_arb_slot.sv
// mem_arb_slot: per-requester capture register; busy mirrors the pending flag.
module mem_arb_slot #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          dispatch_read_in,
    input  logic          dispatch_write_in,
    input  logic [AW-1:0] addr_in,
    input  logic [MW-1:0] width_in,
    input  logic [DW-1:0] wdata_in,
    input  logic          done_in,
    input  logic [DW-1:0] rdata_in,
    output logic          busy_out,
    output logic          op_write_out,
    output logic [AW-1:0] addr_out,
    output logic [MW-1:0] width_out,
    output logic [DW-1:0] wdata_out,
    output logic [DW-1:0] read_data_out
);
    logic          pending_q, pending_d, op_write_q, op_write_d, capture;
    logic [AW-1:0] addr_q, addr_d;
    logic [MW-1:0] width_q, width_d;
    logic [DW-1:0] wdata_q, wdata_d, read_data_q, read_data_d;

    // A pulse seen while busy (including the completion cycle) is dropped.
    always_comb begin
        capture     = (dispatch_read_in || dispatch_write_in) && !pending_q;
        pending_d   = capture ? 1'b1 : (done_in ? 1'b0 : pending_q);
        op_write_d  = capture ? dispatch_write_in : op_write_q;
        addr_d      = capture ? addr_in : addr_q;
        width_d     = capture ? width_in : width_q;
        wdata_d     = capture ? wdata_in : wdata_q;
        read_data_d = (done_in && !op_write_q) ? rdata_in : read_data_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pending_q   <= 1'b0;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            width_q     <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
        end else begin
            pending_q   <= pending_d;
            op_write_q  <= op_write_d;
            addr_q      <= addr_d;
            width_q     <= width_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
        end
    end

    assign busy_out      = pending_q;
    assign op_write_out  = op_write_q;
    assign addr_out      = addr_q;
    assign width_out     = width_q;
    assign wdata_out     = wdata_q;
    assign read_data_out = read_data_q;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between a CPU port (req0) and an aux master (req1).
// Define MEM_ARB_FIXED_PRIORITY_EN to make req0 win every tie instead of round-robin.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MW_WIDTH   = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  r0_dispatch_read_in,
    input  logic                  r0_dispatch_write_in,
    input  logic [ADDR_WIDTH-1:0] r0_addr_in,
    input  logic [MW_WIDTH-1:0]   r0_mem_width_in,
    input  logic [DATA_WIDTH-1:0] r0_write_data_in,
    output logic                  r0_busy_out,
    output logic [DATA_WIDTH-1:0] r0_read_data_out,
    input  logic                  r1_dispatch_read_in,
    input  logic                  r1_dispatch_write_in,
    input  logic [ADDR_WIDTH-1:0] r1_addr_in,
    input  logic [MW_WIDTH-1:0]   r1_mem_width_in,
    input  logic [DATA_WIDTH-1:0] r1_write_data_in,
    output logic                  r1_busy_out,
    output logic [DATA_WIDTH-1:0] r1_read_data_out,
    output logic                  m_dispatch_read_out,
    output logic                  m_dispatch_write_out,
    output logic [ADDR_WIDTH-1:0] m_addr_out,
    output logic [MW_WIDTH-1:0]   m_mem_width_out,
    output logic [DATA_WIDTH-1:0] m_write_data_out,
    input  logic                  m_busy_in,
    input  logic [DATA_WIDTH-1:0] m_read_data_in
);
    arb_state_t            state_q, state_d;
    logic                  cur_q, cur_d, grant, m_rd_q, m_rd_d, m_wr_q, m_wr_d;
    logic [1:0]            pend, op_write, done;
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [MW_WIDTH-1:0]   width [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [MW_WIDTH-1:0]   m_width_q, m_width_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;

    mem_arb_slot #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .MW(MW_WIDTH)) u_slot0 (
        .clk_in, .rst_in,
        .dispatch_read_in(r0_dispatch_read_in), .dispatch_write_in(r0_dispatch_write_in),
        .addr_in(r0_addr_in), .width_in(r0_mem_width_in), .wdata_in(r0_write_data_in),
        .done_in(done[REQ_CPU]), .rdata_in(m_read_data_in),
        .busy_out(pend[REQ_CPU]), .op_write_out(op_write[REQ_CPU]), .addr_out(addr[REQ_CPU]),
        .width_out(width[REQ_CPU]), .wdata_out(wdata[REQ_CPU]), .read_data_out(r0_read_data_out)
    );

    mem_arb_slot #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .MW(MW_WIDTH)) u_slot1 (
        .clk_in, .rst_in,
        .dispatch_read_in(r1_dispatch_read_in), .dispatch_write_in(r1_dispatch_write_in),
        .addr_in(r1_addr_in), .width_in(r1_mem_width_in), .wdata_in(r1_write_data_in),
        .done_in(done[REQ_AUX]), .rdata_in(m_read_data_in),
        .busy_out(pend[REQ_AUX]), .op_write_out(op_write[REQ_AUX]), .addr_out(addr[REQ_AUX]),
        .width_out(width[REQ_AUX]), .wdata_out(wdata[REQ_AUX]), .read_data_out(r1_read_data_out)
    );

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    assign grant = pend[REQ_CPU] ? REQ_CPU : REQ_AUX;
`else
    logic rr_last_q, rr_last_d;
    assign grant = &pend ? ~rr_last_q : (pend[REQ_CPU] ? REQ_CPU : REQ_AUX);
    assign rr_last_d = (state_q == IDLE && |pend) ? grant : rr_last_q;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) rr_last_q <= 1'b1;
        else         rr_last_q <= rr_last_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        m_rd_d    = 1'b0;
        m_wr_d    = 1'b0;
        m_addr_d  = m_addr_q;
        m_width_d = m_width_q;
        m_wdata_d = m_wdata_q;
        done      = 2'b00;
        case (state_q)
            IDLE: if (|pend) begin
                cur_d     = grant;
                m_rd_d    = !op_write[grant];
                m_wr_d    = op_write[grant];
                m_addr_d  = addr[grant];
                m_width_d = width[grant];
                m_wdata_d = wdata[grant];
                state_d   = ISSUE;
            end
            // Memory raises busy one cycle after the pulse, so skip sampling it here.
            ISSUE: state_d = WAIT;
            WAIT: if (!m_busy_in) begin
                done[cur_q] = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            cur_q     <= REQ_CPU;
            m_rd_q    <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_width_q <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            m_rd_q    <= m_rd_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_width_q <= m_width_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign r0_busy_out          = pend[REQ_CPU];
    assign r1_busy_out          = pend[REQ_AUX];
    assign m_dispatch_read_out  = m_rd_q;
    assign m_dispatch_write_out = m_wr_q;
    assign m_addr_out           = m_addr_q;
    assign m_mem_width_out      = m_width_q;
    assign m_write_data_out     = m_wdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of capture, arbitration, latency and async reset.
module tb_mem_bus_arbiter;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic        clk_in = 1'b0, rst_in = 1'b0;
    logic        r0_dispatch_read_in, r0_dispatch_write_in, r0_busy_out;
    logic        r1_dispatch_read_in, r1_dispatch_write_in, r1_busy_out;
    logic [31:0] r0_addr_in, r0_write_data_in, r0_read_data_out;
    logic [31:0] r1_addr_in, r1_write_data_in, r1_read_data_out;
    logic [1:0]  r0_mem_width_in, r1_mem_width_in, m_mem_width_out;
    logic        m_dispatch_read_out, m_dispatch_write_out, m_busy_in;
    logic [31:0] m_addr_out, m_write_data_out, m_read_data_in;
    logic [31:0] mem_rdata = '0;
    int          checks = 0, failures = 0, rd_n = 0, wr_n = 0, cnt = 0, mem_k = 0, rd0, wr0;

    always #5 clk_in = ~clk_in;

    mem_bus_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .r0_dispatch_read_in(r0_dispatch_read_in), .r0_dispatch_write_in(r0_dispatch_write_in),
        .r0_addr_in(r0_addr_in), .r0_mem_width_in(r0_mem_width_in), .r0_write_data_in(r0_write_data_in),
        .r0_busy_out(r0_busy_out), .r0_read_data_out(r0_read_data_out),
        .r1_dispatch_read_in(r1_dispatch_read_in), .r1_dispatch_write_in(r1_dispatch_write_in),
        .r1_addr_in(r1_addr_in), .r1_mem_width_in(r1_mem_width_in), .r1_write_data_in(r1_write_data_in),
        .r1_busy_out(r1_busy_out), .r1_read_data_out(r1_read_data_out),
        .m_dispatch_read_out(m_dispatch_read_out), .m_dispatch_write_out(m_dispatch_write_out),
        .m_addr_out(m_addr_out), .m_mem_width_out(m_mem_width_out), .m_write_data_out(m_write_data_out),
        .m_busy_in(m_busy_in), .m_read_data_in(m_read_data_in)
    );

    // Memory model: busy for mem_k cycles starting the cycle after a dispatch pulse.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) cnt <= 0;
        else if (m_dispatch_read_out || m_dispatch_write_out) cnt <= mem_k;
        else if (cnt != 0) cnt <= cnt - 1;
    end
    assign m_busy_in      = (cnt != 0);
    assign m_read_data_in = mem_rdata;

    always @(posedge clk_in) begin
        if (m_dispatch_read_out) rd_n <= rd_n + 1;
        if (m_dispatch_write_out) wr_n <= wr_n + 1;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit n, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        if (n) begin
            r1_dispatch_read_in = rd; r1_dispatch_write_in = wr; r1_addr_in = a; r1_write_data_in = wd;
        end else begin
            r0_dispatch_read_in = rd; r0_dispatch_write_in = wr; r0_addr_in = a; r0_write_data_in = wd;
        end
    endtask

    task automatic clear_reqs();
        r0_dispatch_read_in = 0; r0_dispatch_write_in = 0;
        r1_dispatch_read_in = 0; r1_dispatch_write_in = 0;
    endtask

    task automatic wait_free(input string tag);
        int i = 0;
        while ((r0_busy_out || r1_busy_out) && i < 50) begin
            tick();
            i++;
        end
        chk(tag, 64'(i < 50), 64'd1);
    endtask

    initial begin
        clear_reqs();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        r0_mem_width_in = 2'd2;
        r1_mem_width_in = 2'd1;
        #1;
        chk("reset_busy", {r1_busy_out, r0_busy_out}, 0);
        chk("reset_pulses", {m_dispatch_read_out, m_dispatch_write_out}, 0);
        chk("reset_maddr", m_addr_out, 0);
        chk("reset_rdata", {r1_read_data_out, r0_read_data_out}, 0);
        tick();
        rst_in = 1;
        tick();

        // Tie straight after reset: req0 first, req1 after req0 completes.
        mem_k = 2; mem_rdata = 32'hCAFE_0001;
        set_req(0, 0, 1, 32'h200, 32'h11);
        set_req(1, 1, 0, 32'h300, 32'h0);
        tick();
        clear_reqs();
        chk("tie_busy", {r1_busy_out, r0_busy_out}, 2'b11);
        tick();
        chk("tie_first_wr", {m_dispatch_read_out, m_dispatch_write_out}, 2'b01);
        chk("tie_first_addr", m_addr_out, 32'h200);
        chk("tie_first_wdata", m_write_data_out, 32'h11);
        tick(4);
        chk("tie_r0_done", {r1_busy_out, r0_busy_out}, 2'b10);
        tick();
        chk("tie_second_rd", {m_dispatch_read_out, m_dispatch_write_out}, 2'b10);
        chk("tie_second_addr", m_addr_out, 32'h300);
        chk("tie_second_width", m_mem_width_out, 2'd1);
        tick(4);
        chk("tie_r1_done", r1_busy_out, 0);
        chk("tie_r1_rdata", r1_read_data_out, 32'hCAFE_0001);
        chk("tie_r0_rdata_kept", r0_read_data_out, 0);

        // Single uncontended read, 3 busy cycles: busy falls 7 cycles after dispatch.
        mem_k = 3; mem_rdata = 32'hDEAD_BEEF; rd0 = rd_n;
        set_req(0, 1, 0, 32'h100, 32'h11);
        tick();
        clear_reqs();
        chk("rd_busy_t1", r0_busy_out, 1);
        chk("rd_no_pulse_t1", m_dispatch_read_out, 0);
        tick();
        chk("rd_pulse_t2", m_dispatch_read_out, 1);
        chk("rd_addr", m_addr_out, 32'h100);
        chk("rd_width", m_mem_width_out, 2'd2);
        tick();
        chk("rd_pulse_end_t3", m_dispatch_read_out, 0);
        tick(3);
        chk("rd_busy_t6", r0_busy_out, 1);
        tick();
        chk("rd_busy_t7", r0_busy_out, 0);
        chk("rd_data", r0_read_data_out, 32'hDEAD_BEEF);
        chk("rd_one_pulse", rd_n - rd0, 1);

        // Tie after a req0 grant: round-robin hands it to req1.
        mem_k = 1; mem_rdata = 32'h5555_AAAA;
        set_req(0, 1, 0, 32'h500, 32'h0);
        set_req(1, 0, 1, 32'h600, 32'h22);
        tick();
        clear_reqs();
        tick();
        chk("tie2_first_addr", m_addr_out, FIXED ? 32'h500 : 32'h600);
        chk("tie2_first_wr", m_dispatch_write_out, FIXED ? 1'b0 : 1'b1);
        tick(4);
        chk("tie2_second_addr", m_addr_out, FIXED ? 32'h600 : 32'h500);
        wait_free("tie2_timeout");
        chk("tie2_r0_rdata", r0_read_data_out, 32'h5555_AAAA);

        // Read and write together count as a write; read data untouched.
        mem_k = 2; mem_rdata = 32'hBAD0_BAD0; rd0 = rd_n; wr0 = wr_n;
        set_req(1, 1, 1, 32'h40, 32'h33);
        tick();
        clear_reqs();
        wait_free("both_timeout");
        chk("both_wr_pulses", wr_n - wr0, 1);
        chk("both_rd_pulses", rd_n - rd0, 0);
        chk("both_rdata_kept", r1_read_data_out, 32'hCAFE_0001);
        chk("both_addr_held", m_addr_out, 32'h40);
        chk("both_wdata_held", m_write_data_out, 32'h33);

        // Second dispatch while busy is ignored.
        mem_k = 2; mem_rdata = 32'h0BAD_F00D; rd0 = rd_n;
        set_req(0, 1, 0, 32'h700, 32'h0);
        tick();
        set_req(0, 1, 0, 32'h704, 32'h0);
        tick();
        clear_reqs();
        wait_free("viol_timeout");
        chk("viol_one_pulse", rd_n - rd0, 1);
        chk("viol_addr", m_addr_out, 32'h700);
        chk("viol_rdata", r0_read_data_out, 32'h0BAD_F00D);
        tick();
        chk("viol_no_recapture", r0_busy_out, 0);

        // Async reset in WAIT, then a fresh req1 read with a zero-wait memory.
        mem_k = 5;
        set_req(0, 1, 0, 32'h800, 32'h0);
        tick();
        clear_reqs();
        tick(3);
        #2 rst_in = 0;
        #1;
        chk("arst_busy", {r1_busy_out, r0_busy_out}, 0);
        chk("arst_maddr", m_addr_out, 0);
        chk("arst_mwdata", m_write_data_out, 0);
        chk("arst_rdata", {r1_read_data_out, r0_read_data_out}, 0);
        @(posedge clk_in);
        #1 rst_in = 1;
        tick();
        mem_k = 0; mem_rdata = 32'h1234_5678; rd0 = rd_n;
        set_req(1, 1, 0, 32'h900, 32'h0);
        tick();
        clear_reqs();
        tick();
        chk("post_rst_pulse", m_dispatch_read_out, 1);
        chk("post_rst_addr", m_addr_out, 32'h900);
        wait_free("post_rst_timeout");
        chk("post_rst_rdata", r1_read_data_out, 32'h1234_5678);
        chk("post_rst_no_reissue", rd_n - rd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
